// File: rtl/edge_event_arbiter.sv
// Edge-event controller: synchronise NCH inputs, detect edges, round-robin one event at a time to the consumer.
// Latency: input change sampled at posedge k sets pending at k+2 and offers after k+3; debounce adds DB_CYCLES.
// Backpressure: an offer is held until evt_ready; one slot per channel, further edges merge and set sticky overflow.
// Optional: define DEBOUNCE_EN to require DB_CYCLES stable cycles before a level change is accepted.
module edge_event_arbiter #(
    parameter int NCH       = 4,
    parameter int HOLDOFF   = 200,
    parameter int DB_CYCLES = 16,
    localparam int CW       = (NCH > 2) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] sig_in,
    input  logic           enable,
    input  logic           evt_ready,
    input  logic           overflow_clr,
    output logic           evt_valid,
    output logic [CW-1:0]  evt_ch,
    output logic           evt_rise,
    output logic [NCH-1:0] overflow,
    output logic           armed
);

    localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF + 1) : 1;
    localparam logic [HW-1:0] HO_LAST = HW'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

    typedef enum logic {ST_IDLE, ST_OFFER} state_t;

    state_t         state_q, state_d;
    logic [NCH-1:0] s1_q, s1_d, s2_q, s2_d;
    logic [NCH-1:0] lvl_q, lvl_d, lvl_upd, edge_evt;
    logic [NCH-1:0] pend_q, pend_d, ptype_q, ptype_d;
    logic [NCH-1:0] ovf_q, ovf_d, ovf_set;
    logic [HW-1:0]  hcnt_q, hcnt_d;
    logic           armed_q, armed_d;
    logic [CW-1:0]  last_q, last_d;
    logic           evt_valid_q, evt_valid_d;
    logic [CW-1:0]  evt_ch_q, evt_ch_d;
    logic           evt_rise_q, evt_rise_d;
    logic           grant_vld;
    logic [CW-1:0]  grant_ch;

    always_comb begin
        s1_d = sig_in;
        s2_d = s1_q;
    end

    always_comb begin
        hcnt_d  = hcnt_q;
        armed_d = armed_q;
        if (!armed_q) begin
            hcnt_d = hcnt_q + 1'b1;
            if (HOLDOFF == 0 || hcnt_q == HO_LAST) begin
                armed_d = 1'b1;
            end
        end
    end

`ifdef DEBOUNCE_EN
    localparam int DBW = (DB_CYCLES > 0) ? $clog2(DB_CYCLES + 1) : 1;
    localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES);

    logic [DBW-1:0] dbc_q [NCH];
    logic [DBW-1:0] dbc_d [NCH];

    // A level change is accepted only once the mismatch has persisted past the window.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            dbc_d[i]   = '0;
            lvl_upd[i] = 1'b0;
            if (!armed_q) begin
                lvl_upd[i] = 1'b1;
            end else if (s2_q[i] != lvl_q[i]) begin
                if (dbc_q[i] == DB_LAST) begin
                    lvl_upd[i] = 1'b1;
                end else begin
                    dbc_d[i] = dbc_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (rst) begin
                dbc_q[i] <= '0;
            end else begin
                dbc_q[i] <= dbc_d[i];
            end
        end
    end
`else
    always_comb begin
        lvl_upd = '1;
    end
`endif

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            lvl_d[i]    = lvl_upd[i] ? s2_q[i] : lvl_q[i];
            edge_evt[i] = armed_q & lvl_upd[i] & (s2_q[i] ^ lvl_q[i]);
        end
    end

    // Round-robin search starting one past the last granted channel.
    always_comb begin
        int            sum;
        logic [CW-1:0] idx;
        grant_vld = 1'b0;
        grant_ch  = '0;
        sum       = 0;
        idx       = '0;
        if (state_q == ST_IDLE && enable) begin
            for (int off = 1; off <= NCH; off++) begin
                sum = int'(last_q) + off;
                if (sum >= NCH) begin
                    sum = sum - NCH;
                end
                idx = CW'(sum);
                if (!grant_vld && pend_q[idx]) begin
                    grant_vld = 1'b1;
                    grant_ch  = idx;
                end
            end
        end
    end

    always_comb begin
        pend_d  = pend_q;
        ptype_d = ptype_q;
        ovf_set = '0;
        for (int i = 0; i < NCH; i++) begin
            if (edge_evt[i]) begin
                pend_d[i]  = 1'b1;
                ptype_d[i] = s2_q[i];
                if (pend_q[i] && !(grant_vld && grant_ch == CW'(i))) begin
                    ovf_set[i] = 1'b1;
                end
            end else if (grant_vld && grant_ch == CW'(i)) begin
                pend_d[i] = 1'b0;
            end
        end
        ovf_d = (ovf_q & ~{NCH{overflow_clr}}) | ovf_set;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (grant_vld) state_d = ST_OFFER;
            ST_OFFER: if (evt_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        evt_valid_d = evt_valid_q;
        evt_ch_d    = evt_ch_q;
        evt_rise_d  = evt_rise_q;
        last_d      = last_q;
        if (grant_vld) begin
            evt_valid_d = 1'b1;
            evt_ch_d    = grant_ch;
            evt_rise_d  = ptype_q[grant_ch];
            last_d      = grant_ch;
        end else if (state_q == ST_OFFER && evt_ready) begin
            evt_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            s1_q        <= '0;
            s2_q        <= '0;
            lvl_q       <= '0;
            pend_q      <= '0;
            ptype_q     <= '0;
            ovf_q       <= '0;
            hcnt_q      <= '0;
            armed_q     <= 1'b0;
            last_q      <= CW'(NCH - 1);
            evt_valid_q <= 1'b0;
            evt_ch_q    <= '0;
            evt_rise_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            lvl_q       <= lvl_d;
            pend_q      <= pend_d;
            ptype_q     <= ptype_d;
            ovf_q       <= ovf_d;
            hcnt_q      <= hcnt_d;
            armed_q     <= armed_d;
            last_q      <= last_d;
            evt_valid_q <= evt_valid_d;
            evt_ch_q    <= evt_ch_d;
            evt_rise_q  <= evt_rise_d;
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_ch    = evt_ch_q;
    assign evt_rise  = evt_rise_q;
    assign overflow  = ovf_q;
    assign armed     = armed_q;

endmodule
